// File: rtl/fixed_point_accumulator.sv
// Fixed-point accumulator: sums a stream of {scale, number} products in a wide
// signed register (FRAC_MAX fractional bits), then searches downward from the
// finest scale for the first one whose value fits a 13-bit signed number.
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its payload stable while valid is high and ready is
// low. in_ready and out_valid come from registers and never depend on
// out_ready or in_valid in the same cycle.
module fixed_point_accumulator #(
  parameter int ACC_W    = 24,
  parameter int FRAC_MAX = 7,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_ovf,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_NORM  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [2:0]              S_TOP   = 3'(FRAC_MAX);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    sticky;
  logic [2:0]              trial_s;

  logic [2:0]              shamt_in;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W:0]   sum_wide;
  logic                    sat_hit;
  logic signed [ACC_W-1:0] sat_sum;
  logic [2:0]              shamt_norm;
  logic signed [ACC_W-1:0] norm_v;
  logic                    v_fits;

  assign dbg_state = state;

  // Datapath: align the incoming term, saturating add, and trial renormalisation.
  always_comb begin
    shamt_in   = S_TOP - in_data[15:13];
    term       = {{(ACC_W-13){in_data[12]}}, in_data[12:0]} <<< shamt_in;
    sum_wide   = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    sat_hit    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sat_sum    = sat_hit ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    shamt_norm = S_TOP - trial_s;
    norm_v     = acc >>> shamt_norm;
    // A 13-bit signed value has all bits from 12 upward equal to the sign.
    v_fits     = (&norm_v[ACC_W-1:12]) | ~(|norm_v[ACC_W-1:12]);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ACCUM;
      acc          <= '0;
      count        <= '0;
      sticky       <= 1'b0;
      trial_s      <= S_TOP;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            acc    <= sat_sum;
            sticky <= sticky | in_ovf | sat_hit;
            if (count != '1) count <= count + 1'b1;
            if (in_last) begin
              state    <= ST_NORM;
              trial_s  <= S_TOP;
              in_ready <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          if (v_fits) begin
            out_data     <= {trial_s, norm_v[12:0]};
            out_overflow <= sticky;
            out_count    <= count;
            out_valid    <= 1'b1;
            state        <= ST_HOLD;
          end else if (trial_s != 3'd0) begin
            trial_s <= trial_s - 3'd1;
          end else begin
            // Even integer scale cannot hold the sum: clamp and flag it.
            out_data     <= {3'd0, norm_v[ACC_W-1] ? 13'h1000 : 13'h0FFF};
            sticky       <= 1'b1;
            out_overflow <= 1'b1;
            out_count    <= count;
            out_valid    <= 1'b1;
            state        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state    <= ST_ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
